// File: rtl/synth_pkg.sv
// Shared synthesizer types and constants used by the voice-level blocks.
package synth_pkg;

    localparam int NUM_VOICES = 8;
    localparam int VEL_WIDTH  = 3;
    localparam int NOTE_WIDTH = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_voice.sv
// Single ADSR voice: gate edge capture, envelope FSM with clamped steps and
// optional velocity scaling of the output (enabled by ADSR_VELOCITY_EN).
module adsr_voice
    import synth_pkg::*;
#(
    parameter int                   ENV_WIDTH     = 16,
    parameter logic [ENV_WIDTH-1:0] ATTACK_STEP   = 16'd64,
    parameter logic [ENV_WIDTH-1:0] DECAY_STEP    = 16'd16,
    parameter logic [ENV_WIDTH-1:0] SUSTAIN_LEVEL = 16'd40000,
    parameter logic [ENV_WIDTH-1:0] RELEASE_STEP  = 16'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 on_in,
    input  logic [VEL_WIDTH-1:0] velocity_in,
    output logic [ENV_WIDTH-1:0] env_out,
    output logic                 active_out
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = {ENV_WIDTH{1'b1}};

    adsr_state_t          state_r;
    adsr_state_t          state_next_s;
    logic [ENV_WIDTH-1:0] level_r;
    logic [ENV_WIDTH-1:0] level_next_s;
    logic                 on_prev_r;
    logic                 trig_r;
    logic                 rise_s;
    logic                 trig_eff_s;
    logic [ENV_WIDTH:0]   inc_s;
    logic [ENV_WIDTH:0]   dec_s;
    logic [ENV_WIDTH:0]   rel_s;
    logic [ENV_WIDTH-1:0] env_r;
    logic                 active_r;

    assign rise_s     = on_in & ~on_prev_r;
    // A rise coinciding with the tick must win over the sticky flag's clear.
    assign trig_eff_s = trig_r | rise_s;
    assign inc_s      = {1'b0, level_r} + {1'b0, ATTACK_STEP};
    assign dec_s      = {1'b0, level_r} - {1'b0, DECAY_STEP};
    assign rel_s      = {1'b0, level_r} - {1'b0, RELEASE_STEP};

`ifdef ADSR_VELOCITY_EN
    logic [VEL_WIDTH-1:0] vel_r;

    function automatic logic [ENV_WIDTH-1:0] scale_level(
        input logic [ENV_WIDTH-1:0] lvl,
        input logic [VEL_WIDTH-1:0] vel
    );
        logic [ENV_WIDTH+2:0] prod;
        prod = {3'b000, lvl} * ({{ENV_WIDTH{1'b0}}, vel} + {{(ENV_WIDTH+2){1'b0}}, 1'b1});
        return prod[ENV_WIDTH+2:3];
    endfunction

    // Latch velocity on each gate rise
    always_ff @(posedge clk) begin
        if (rst) begin
            vel_r <= 3'd0;
        end else if (rise_s) begin
            vel_r <= velocity_in;
        end else begin
            vel_r <= vel_r;
        end
    end
`else
    logic unused_vel_s;
    assign unused_vel_s = ^velocity_in;
`endif

    // Gate edge detector and sticky trigger, cleared by each sample tick
    always_ff @(posedge clk) begin
        if (rst) begin
            on_prev_r <= 1'b0;
            trig_r    <= 1'b0;
        end else begin
            on_prev_r <= on_in;
            if (sample_tick) begin
                trig_r <= 1'b0;
            end else if (rise_s) begin
                trig_r <= 1'b1;
            end else begin
                trig_r <= trig_r;
            end
        end
    end

    // Envelope next-state and level computation
    always_comb begin
        state_next_s = state_r;
        level_next_s = level_r;
        if (sample_tick && trig_eff_s) begin
            state_next_s = ST_ATTACK;
        end else if (sample_tick && !on_in &&
                     (state_r == ST_ATTACK || state_r == ST_DECAY || state_r == ST_SUSTAIN)) begin
            state_next_s = ST_RELEASE;
        end else if (sample_tick) begin
            case (state_r)
                ST_ATTACK: begin
                    if (inc_s >= {1'b0, ENV_MAX}) begin
                        level_next_s = ENV_MAX;
                        state_next_s = ST_DECAY;
                    end else begin
                        level_next_s = inc_s[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_s[ENV_WIDTH] || (dec_s[ENV_WIDTH-1:0] <= SUSTAIN_LEVEL)) begin
                        level_next_s = SUSTAIN_LEVEL;
                        state_next_s = ST_SUSTAIN;
                    end else begin
                        level_next_s = dec_s[ENV_WIDTH-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    level_next_s = level_r;
                end
                ST_RELEASE: begin
                    if (rel_s[ENV_WIDTH] || (rel_s[ENV_WIDTH-1:0] == {ENV_WIDTH{1'b0}})) begin
                        level_next_s = {ENV_WIDTH{1'b0}};
                        state_next_s = ST_IDLE;
                    end else begin
                        level_next_s = rel_s[ENV_WIDTH-1:0];
                    end
                end
                ST_IDLE: begin
                    level_next_s = {ENV_WIDTH{1'b0}};
                end
                default: begin
                    level_next_s = {ENV_WIDTH{1'b0}};
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
            level_next_s = level_r;
        end
    end

    // Envelope state and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            level_r <= {ENV_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            level_r <= level_next_s;
        end
    end

    // Registered amplitude and activity outputs, one cycle behind the level
    always_ff @(posedge clk) begin
        if (rst) begin
            env_r    <= {ENV_WIDTH{1'b0}};
            active_r <= 1'b0;
        end else begin
`ifdef ADSR_VELOCITY_EN
            env_r    <= scale_level(level_r, vel_r);
`else
            env_r    <= level_r;
`endif
            active_r <= (state_r != ST_IDLE);
        end
    end

    assign env_out    = env_r;
    assign active_out = active_r;

endmodule

// File: rtl/adsr_envelope.sv
// Eight-voice ADSR envelope generator sharing one sample tick.
// Velocity scaling of env_out is enabled by defining ADSR_VELOCITY_EN.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int                   ENV_WIDTH     = 16,
    parameter logic [ENV_WIDTH-1:0] ATTACK_STEP   = 16'd64,
    parameter logic [ENV_WIDTH-1:0] DECAY_STEP    = 16'd16,
    parameter logic [ENV_WIDTH-1:0] SUSTAIN_LEVEL = 16'd40000,
    parameter logic [ENV_WIDTH-1:0] RELEASE_STEP  = 16'd8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sample_tick,
    input  logic [NUM_VOICES-1:0]                 on_in,
    input  logic [NUM_VOICES-1:0][VEL_WIDTH-1:0]  velocity_in,
    output logic [NUM_VOICES-1:0][ENV_WIDTH-1:0]  env_out,
    output logic [NUM_VOICES-1:0]                 active_out
);

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        adsr_voice #(
            .ENV_WIDTH    (ENV_WIDTH),
            .ATTACK_STEP  (ATTACK_STEP),
            .DECAY_STEP   (DECAY_STEP),
            .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_voice (
            .clk        (clk),
            .rst        (rst),
            .sample_tick(sample_tick),
            .on_in      (on_in[i]),
            .velocity_in(velocity_in[i]),
            .env_out    (env_out[i]),
            .active_out (active_out[i])
        );
    end

endmodule
